// File: rtl/cmul_pkg.sv
// Shared constants for the complex-multiplier arbiter: operand/result field positions and tag sizing.
package cmul_pkg;

    localparam int DEF_DATA_WIDTH = 8;

    // Field positions in units of one component width (bit offset = index * DATA_WIDTH), MSB first
    localparam int A_RE = 3;
    localparam int A_IM = 2;
    localparam int B_RE = 1;
    localparam int B_IM = 0;

    // Result halves in units of 4*DATA_WIDTH
    localparam int RES_RE = 1;
    localparam int RES_IM = 0;

    function automatic int tag_w(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/cmul_tag_fifo.sv
// In-order FIFO of requester tags; the head names the owner of the oldest outstanding operation.
module cmul_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 2
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         clr,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read when count says they are valid
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/cmul_arbiter.sv
// Round-robin arbiter sharing one complex multiplier; results are routed back by an in-order tag FIFO.
// Optional per-requester grant counters are built when CMUL_ARB_STATS_EN is defined.
module cmul_arbiter
    import cmul_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_REQ    = 4,
    parameter int TAG_DEPTH  = 4
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              sw_rst,
    input  logic [NUM_REQ-1:0]                req_val,
    output logic [NUM_REQ-1:0]                req_ready,
    input  logic [NUM_REQ*4*DATA_WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]                rsp_val,
    input  logic [NUM_REQ-1:0]                rsp_ready,
    output logic [8*DATA_WIDTH-1:0]           rsp_data,
    output logic                              op_val,
    input  logic                              op_ready,
    output logic [4*DATA_WIDTH-1:0]           op_data,
    input  logic                              res_val,
    output logic                              res_ready,
    input  logic [8*DATA_WIDTH-1:0]           res_data,
`ifdef CMUL_ARB_STATS_EN
    output logic [NUM_REQ*16-1:0]             grant_cnt,
`endif
    output logic                              orphan_err
);

    localparam int OPW = 4 * DATA_WIDTH;
    localparam int TW  = tag_w(NUM_REQ);

    logic [TW-1:0] rr_ptr;
    logic [TW-1:0] rr_sel;
    logic [TW-1:0] sel;
    logic [TW-1:0] lock_sel;
    logic          lock_active;
    logic          any_val;
    logic          hs;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [TW-1:0] head;

    // Search begins just past the last grant so every requester gets a turn
    always_comb begin
        int idx;
        logic found;
        rr_sel = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!found && req_val[idx]) begin
                rr_sel = TW'(idx);
                found  = 1'b1;
            end
        end
    end

    assign any_val = |req_val;
    assign sel     = lock_active ? lock_sel : rr_sel;
    assign op_val  = any_val & ~fifo_full & ~sw_rst;
    assign op_data = req_data[int'(sel)*OPW +: OPW];
    assign hs      = op_val & op_ready;

    always_comb begin
        req_ready      = '0;
        req_ready[sel] = hs;
    end

    // A stalled offer is frozen so late requesters cannot swap op_data mid-transfer
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_ptr      <= TW'(NUM_REQ - 1);
            lock_active <= 1'b0;
            lock_sel    <= '0;
        end else if (sw_rst) begin
            rr_ptr      <= TW'(NUM_REQ - 1);
            lock_active <= 1'b0;
            lock_sel    <= '0;
        end else if (hs) begin
            rr_ptr      <= sel;
            lock_active <= 1'b0;
        end else if (op_val) begin
            lock_active <= 1'b1;
            lock_sel    <= sel;
        end
    end

    cmul_tag_fifo #(
        .DEPTH (TAG_DEPTH),
        .W     (TW)
    ) u_tag_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .clr   (sw_rst),
        .push  (hs),
        .pop   (pop),
        .din   (sel),
        .head  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // With no owner on record the result is drained and flagged
    assign res_ready = fifo_empty ? 1'b1 : rsp_ready[head];
    assign pop       = res_val & res_ready & ~fifo_empty;
    assign rsp_data  = res_data;

    always_comb begin
        rsp_val = '0;
        if (!fifo_empty) rsp_val[head] = res_val;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)       orphan_err <= 1'b0;
        else if (sw_rst) orphan_err <= 1'b0;
        else             orphan_err <= res_val & fifo_empty;
    end

`ifdef CMUL_ARB_STATS_EN
    logic [15:0] cnt [NUM_REQ];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int g = 0; g < NUM_REQ; g++) cnt[g] <= '0;
        end else if (sw_rst) begin
            for (int g = 0; g < NUM_REQ; g++) cnt[g] <= '0;
        end else begin
            for (int g = 0; g < NUM_REQ; g++) begin
                if (hs && sel == TW'(g) && cnt[g] != 16'hFFFF) cnt[g] <= cnt[g] + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt_out
        assign grant_cnt[g*16 +: 16] = cnt[g];
    end
`endif

endmodule

// File: tb/tb_cmul_arbiter.sv
// Bench for cmul_arbiter with a 2-cycle model multiplier and a result scoreboard.
module tb_cmul_arbiter;

    localparam int DW  = 8;
    localparam int NR  = 4;
    localparam int TD  = 4;
    localparam int OPW = 4 * DW;
    localparam int RW  = 8 * DW;
    localparam int EW  = 8 + RW;

    logic              clk = 1'b0;
    logic              rstn;
    logic              sw_rst;
    logic [NR-1:0]     req_val;
    logic [NR-1:0]     req_ready;
    logic [NR*OPW-1:0] req_data;
    logic [NR-1:0]     rsp_val;
    logic [NR-1:0]     rsp_ready;
    logic [RW-1:0]     rsp_data;
    logic              op_val;
    logic              op_ready;
    logic [OPW-1:0]    op_data;
    logic              res_val;
    logic              res_ready;
    logic [RW-1:0]     res_data;
    logic              orphan_err;
`ifdef CMUL_ARB_STATS_EN
    logic [NR*16-1:0]  grant_cnt;
`endif

    cmul_arbiter #(
        .DATA_WIDTH (DW),
        .NUM_REQ    (NR),
        .TAG_DEPTH  (TD)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .sw_rst     (sw_rst),
        .req_val    (req_val),
        .req_ready  (req_ready),
        .req_data   (req_data),
        .rsp_val    (rsp_val),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .op_val     (op_val),
        .op_ready   (op_ready),
        .op_data    (op_data),
        .res_val    (res_val),
        .res_ready  (res_ready),
        .res_data   (res_data),
`ifdef CMUL_ARB_STATS_EN
        .grant_cnt  (grant_cnt),
`endif
        .orphan_err (orphan_err)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- bench state ----------------
    logic [RW-1:0]  mul_res_q[$];
    int             mul_due_q[$];
    logic [EW-1:0]  exp_q[$];
    int             grant_log[$];
    int             grant_cyc[$];
    int             pend [NR];
    logic [OPW-1:0] cur_data [NR];
    logic           mul_en;
    logic           force_res;
    logic           res_orphan;
    logic [RW-1:0]  orphan_data;
    int             tests = 0;
    int             fails = 0;

    function automatic logic [RW-1:0] cmul(input logic [OPW-1:0] d);
        int ar, ai, br, bi, re, im;
        ar = int'($signed(d[31:24]));
        ai = int'($signed(d[23:16]));
        br = int'($signed(d[15:8]));
        bi = int'($signed(d[7:0]));
        re = ar * br - ai * bi;
        im = ar * bi + ai * br;
        return {re, im};
    endfunction

    // Requesters and model multiplier drive just after the rising edge
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < NR; i++) begin
            req_val[i] = (pend[i] > 0);
            req_data[i*OPW +: OPW] = cur_data[i];
        end
        res_orphan = force_res;
        if (force_res) begin
            res_val  = 1'b1;
            res_data = orphan_data;
        end else if (mul_en && mul_res_q.size() > 0 && cyc >= mul_due_q[0]) begin
            res_val  = 1'b1;
            res_data = mul_res_q[0];
        end else begin
            res_val  = 1'b0;
            res_data = '0;
        end
    end

    // Observer: handshakes seen mid-cycle are the ones committed at the next rising edge
    always @(negedge clk) begin
        if (rstn) begin
            for (int i = 0; i < NR; i++) begin
                if (req_val[i] && req_ready[i]) begin
                    exp_q.push_back({8'(i), cmul(cur_data[i])});
                    grant_log.push_back(i);
                    grant_cyc.push_back(cyc);
                    pend[i]     = pend[i] - 1;
                    cur_data[i] = $urandom;
                end
            end
            if (op_val && op_ready) begin
                mul_res_q.push_back(cmul(op_data));
                mul_due_q.push_back(cyc + 2);
            end
            if (res_val && res_ready && !res_orphan && mul_res_q.size() > 0) begin
                void'(mul_res_q.pop_front());
                void'(mul_due_q.pop_front());
            end
            if (rsp_val != '0) begin
                tests++;
                if ($countones(rsp_val) != 1) begin
                    fails++;
                    $display("FAIL rsp_onehot: rsp_val=%b, need exactly one bit", rsp_val);
                end
                for (int i = 0; i < NR; i++) begin
                    if (rsp_val[i] && rsp_ready[i]) begin
                        logic [EW-1:0] e;
                        tests++;
                        if (exp_q.size() == 0) begin
                            fails++;
                            $display("FAIL rsp_unexpected: req %0d data %h, none expected", i, rsp_data);
                        end else begin
                            e = exp_q.pop_front();
                            if ({8'(i), rsp_data} !== e) begin
                                fails++;
                                $display("FAIL rsp_data: got req %0d data %h, want req %0d data %h",
                                         i, rsp_data, e[EW-1:RW], e[RW-1:0]);
                            end
                        end
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_model();
        mul_res_q.delete();
        mul_due_q.delete();
        exp_q.delete();
        grant_log.delete();
        grant_cyc.delete();
    endtask

    task automatic apply_rstn();
        step();
        rstn = 1'b0;
        for (int i = 0; i < NR; i++) pend[i] = 0;
        force_res = 1'b0;
        clear_model();
        step();
        step();
        rstn = 1'b1;
    endtask

    task automatic wait_drain(input string name, input int budget);
        bit done;
        done = 1'b0;
        for (int k = 0; k < budget && !done; k++) begin
            done = (exp_q.size() == 0) && (mul_res_q.size() == 0);
            for (int i = 0; i < NR; i++) if (pend[i] != 0) done = 1'b0;
            if (!done) step();
        end
        tests++;
        if (!done) begin
            fails++;
            $display("FAIL %s_drain: exp_q=%0d outstanding, want 0 within %0d cycles", name, exp_q.size(), budget);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        mid();
        tests++;
        if ({op_val, req_ready, rsp_val, res_ready, orphan_err} !== {1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL reset_outputs: op_val=%b req_ready=%b rsp_val=%b res_ready=%b orphan=%b, want 0 0000 0000 1 0",
                     op_val, req_ready, rsp_val, res_ready, orphan_err);
        end
    endtask

    task automatic test_single();
        bit seen_op, seen_rsp;
        seen_op  = 1'b0;
        seen_rsp = 1'b0;
        step();
        cur_data[0] = 32'h03020104;
        pend[0]     = 1;
        for (int k = 0; k < 20 && !seen_rsp; k++) begin
            step();
            mid();
            if (op_val && !seen_op) begin
                seen_op = 1'b1;
                tests++;
                if (op_data !== 32'h03020104) begin
                    fails++;
                    $display("FAIL single_op_data: got %h want 03020104", op_data);
                end
            end
            if (rsp_val != '0) begin
                seen_rsp = 1'b1;
                tests++;
                if (rsp_val !== 4'b0001 || rsp_data !== 64'hFFFFFFFB_0000000E) begin
                    fails++;
                    $display("FAIL single_rsp: got val %b data %h want 0001 fffffffb0000000e", rsp_val, rsp_data);
                end
            end
        end
        tests++;
        if (!seen_rsp) begin
            fails++;
            $display("FAIL single_timeout: no rsp_val within 20 cycles, want one");
        end
        wait_drain("single", 20);
    endtask

    task automatic test_round_robin();
        apply_rstn();
        mul_en   = 1'b1;
        op_ready = 1'b1;
        for (int i = 0; i < NR; i++) pend[i] = 8;
        wait_drain("rr", 200);
        tests++;
        if (grant_log.size() != 32) begin
            fails++;
            $display("FAIL rr_count: got %0d grants want 32", grant_log.size());
        end else begin
            for (int k = 0; k < 32; k++) begin
                tests++;
                if (grant_log[k] != k % NR) begin
                    fails++;
                    $display("FAIL rr_order[%0d]: got req %0d want req %0d", k, grant_log[k], k % NR);
                end
                if (k > 0) begin
                    tests++;
                    if (grant_cyc[k] - grant_cyc[k-1] != 1) begin
                        fails++;
                        $display("FAIL rr_rate[%0d]: gap %0d cycles want 1", k, grant_cyc[k] - grant_cyc[k-1]);
                    end
                end
            end
        end
    endtask

    task automatic test_lock();
        logic [OPW-1:0] a;
        a = 32'h11223344;
        clear_model();
        step();
        op_ready    = 1'b0;
        cur_data[2] = a;
        pend[2]     = 1;
        step();
        for (int k = 0; k < 3; k++) begin
            if (k == 1) begin
                cur_data[1] = 32'h55667788;
                pend[1]     = 1;
            end
            mid();
            tests++;
            if (op_val !== 1'b1 || op_data !== a || req_ready !== 4'b0000) begin
                fails++;
                $display("FAIL lock_hold[%0d]: op_val=%b op_data=%h req_ready=%b want 1 %h 0000",
                         k, op_val, op_data, req_ready, a);
            end
            step();
        end
        mid();
        tests++;
        if (op_data !== a) begin
            fails++;
            $display("FAIL lock_late_req: op_data=%h want %h with req 1 now valid", op_data, a);
        end
        step();
        op_ready = 1'b1;
        mid();
        tests++;
        if (req_ready !== 4'b0100 || op_data !== a) begin
            fails++;
            $display("FAIL lock_release: req_ready=%b op_data=%h want 0100 %h", req_ready, op_data, a);
        end
        wait_drain("lock", 40);
        tests++;
        if (grant_log.size() != 2 || grant_log[0] != 2 || grant_log[1] != 1) begin
            fails++;
            $display("FAIL lock_order: got %0d grants first %0d, want 2 grants order 2,1",
                     grant_log.size(), (grant_log.size() > 0) ? grant_log[0] : -1);
        end
    endtask

    task automatic test_full();
        bit got_pop;
        clear_model();
        step();
        mul_en  = 1'b0;
        pend[0] = 2;
        pend[1] = 2;
        pend[3] = 1;
        for (int k = 0; k < 30 && grant_log.size() < 4; k++) begin
            step();
            mid();
        end
        for (int k = 0; k < 3; k++) begin
            step();
            mid();
            tests++;
            if (op_val !== 1'b0 || grant_log.size() != 4) begin
                fails++;
                $display("FAIL full_stall[%0d]: op_val=%b grants=%0d want 0 and 4", k, op_val, grant_log.size());
            end
        end
        step();
        mul_en  = 1'b1;
        got_pop = 1'b0;
        for (int k = 0; k < 20 && !got_pop; k++) begin
            mid();
            if (res_val && res_ready) got_pop = 1'b1;
            else step();
        end
        tests++;
        if (!got_pop || op_val !== 1'b0) begin
            fails++;
            $display("FAIL full_pop_cycle: pop_seen=%b op_val=%b want 1 and 0", got_pop, op_val);
        end
        step();
        mid();
        tests++;
        if (op_val !== 1'b1) begin
            fails++;
            $display("FAIL full_resume: op_val=%b want 1 after one pop", op_val);
        end
        wait_drain("full", 60);
        tests++;
        if (grant_log.size() != 5) begin
            fails++;
            $display("FAIL full_total: got %0d grants want 5", grant_log.size());
        end
    endtask

    task automatic test_orphan();
        step();
        orphan_data = {$urandom, $urandom};
        force_res   = 1'b1;
        step();
        force_res = 1'b0;
        mid();
        tests++;
        if (res_val !== 1'b1 || res_ready !== 1'b1 || rsp_val !== 4'b0000 || orphan_err !== 1'b0) begin
            fails++;
            $display("FAIL orphan_beat: res_val=%b res_ready=%b rsp_val=%b orphan=%b want 1 1 0000 0",
                     res_val, res_ready, rsp_val, orphan_err);
        end
        step();
        mid();
        tests++;
        if (orphan_err !== 1'b1) begin
            fails++;
            $display("FAIL orphan_pulse: orphan_err=%b want 1", orphan_err);
        end
        step();
        mid();
        tests++;
        if (orphan_err !== 1'b0) begin
            fails++;
            $display("FAIL orphan_clear: orphan_err=%b want 0", orphan_err);
        end
    endtask

    task automatic test_sw_rst();
        clear_model();
        step();
        mul_en = 1'b0;
        for (int i = 0; i < 3; i++) pend[i] = 1;
        for (int k = 0; k < 30 && grant_log.size() < 3; k++) step();
        step();
        pend[3] = 1;
        pend[0] = 1;
        step();
        sw_rst = 1'b1;
        mid();
        tests++;
        if (op_val !== 1'b0 || req_ready !== 4'b0000) begin
            fails++;
            $display("FAIL swrst_block: op_val=%b req_ready=%b want 0 0000", op_val, req_ready);
        end
        step();
        sw_rst = 1'b0;
        mul_res_q.delete();
        mul_due_q.delete();
        exp_q.delete();
`ifdef CMUL_ARB_STATS_EN
        tests++;
        if (grant_cnt !== '0) begin
            fails++;
            $display("FAIL swrst_stats: grant_cnt=%h want 0", grant_cnt);
        end
`endif
        mul_en = 1'b1;
        mid();
        tests++;
        if (res_ready !== 1'b1 || rsp_val !== 4'b0000 || req_ready !== 4'b0001) begin
            fails++;
            $display("FAIL swrst_after: res_ready=%b rsp_val=%b req_ready=%b want 1 0000 0001",
                     res_ready, rsp_val, req_ready);
        end
        wait_drain("swrst", 40);
        tests++;
        if (grant_log.size() != 5 || grant_log[3] != 0 || grant_log[4] != 3) begin
            fails++;
            $display("FAIL swrst_order: got %0d grants, want 5 ending 0,3", grant_log.size());
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rstn        = 1'b0;
        sw_rst      = 1'b0;
        req_val     = '0;
        req_data    = '0;
        rsp_ready   = '1;
        op_ready    = 1'b1;
        res_val     = 1'b0;
        res_data    = '0;
        res_orphan  = 1'b0;
        mul_en      = 1'b1;
        force_res   = 1'b0;
        orphan_data = '0;
        for (int i = 0; i < NR; i++) begin
            pend[i]     = 0;
            cur_data[i] = '0;
        end
        repeat (3) @(posedge clk);
        test_reset();
        step();
        rstn = 1'b1;
        test_single();
        test_round_robin();
        test_lock();
        test_full();
        test_orphan();
        test_sw_rst();
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL final_queue: %0d results still expected, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
